wb_mem_arbiter: RTL and testbench

Two-to-one Wishbone arbiter that lets the core's instruction port and data port share one single-port memory slave. Sits between the core's instruction and data buses and the memory. Grants the slave to one master per bus ownership, with round-robin on contention. Includes a watchdog that returns an error when the slave never completes a transfer. Also gates data-port write enable with cyc/stb, so the memory never sees a write outside a valid cycle.

---
 rtl/wb_arb_pkg.sv | 21 ++
 rtl/wb_mem_arbiter_if.sv | 25 ++
 rtl/wb_arb_watchdog.sv | 31 +++
 rtl/wb_mem_arbiter.sv | 125 ++++++++++++
 tb/tb_wb_mem_arbiter.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the two-to-one Wishbone memory arbiter.
package wb_arb_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned SEL_W  = 4;

    localparam logic [SEL_W-1:0] SEL_ALL = 4'hF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

endpackage

// File: rtl/wb_mem_arbiter_if.sv
// Single Wishbone bus: request signals flow master->slave, response slave->master.
interface wb_mem_arbiter_if;
    import wb_arb_pkg::*;

    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] dat_w;
    logic [DATA_W-1:0] dat_r;
    logic [SEL_W-1:0]  sel;
    logic              cyc;
    logic              stb;
    logic              we;
    logic              ack;
    logic              err;

    modport master (
        output addr, dat_w, sel, cyc, stb, we,
        input  dat_r, ack, err
    );

    modport slave (
        input  addr, dat_w, sel, cyc, stb, we,
        output dat_r, ack, err
    );

endinterface

// File: rtl/wb_arb_watchdog.sv
// Counts unanswered strobe cycles and flags a single-cycle expiry at TIMEOUT.
module wb_arb_watchdog #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear,
    input  logic active,
    output logic expire
);

    localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit          WD_EN = (TIMEOUT > 0);

    logic [CNT_W-1:0] cnt_q;

    // A slave response in the same cycle suppresses expiry because active is low then.
    assign expire = WD_EN && active && (cnt_q == CNT_W'(TIMEOUT));

    // Counter restarts on clear or on its own expiry.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clear || expire) begin
            cnt_q <= '0;
        end else if (active && WD_EN) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/wb_mem_arbiter.sv
// Instruction/data Wishbone arbiter in front of one single-port memory slave.
module wb_mem_arbiter
    import wb_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    wb_mem_arbiter_if.slave   iwbs,
    wb_mem_arbiter_if.slave   dwbs,
    wb_mem_arbiter_if.master  mwbm
);

    state_t state_q, state_d;
    grant_t last_q;

    logic i_req, d_req;
    logic gnt_stb;
    logic wd_clear, wd_active, wd_expire;

    assign i_req = iwbs.cyc & iwbs.stb;
    assign d_req = dwbs.cyc & dwbs.stb;

    // Strobe of the current owner, taken from the masters to keep the watchdog off the output mux.
    always_comb begin
        gnt_stb = 1'b0;
        case (state_q)
            GNT_I:   gnt_stb = iwbs.stb;
            GNT_D:   gnt_stb = dwbs.stb;
            default: gnt_stb = 1'b0;
        endcase
    end

    assign wd_clear  = (state_q == IDLE) | mwbm.ack | mwbm.err;
    assign wd_active = (state_q != IDLE) & gnt_stb & ~mwbm.ack & ~mwbm.err;

    wb_arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clear  (wd_clear),
        .active (wd_active),
        .expire (wd_expire)
    );

    // State register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Remember the most recent owner; reset favours the instruction port in the first contest.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            last_q <= GRANT_D;
        end else if (state_q == IDLE && state_d == GNT_I) begin
            last_q <= GRANT_I;
        end else if (state_q == IDLE && state_d == GNT_D) begin
            last_q <= GRANT_D;
        end
    end

    // Next-state: round-robin in IDLE, hold ownership while the owner keeps cyc high.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (i_req && d_req) begin
                    state_d = (last_q == GRANT_D) ? GNT_I : GNT_D;
                end else if (i_req) begin
                    state_d = GNT_I;
                end else if (d_req) begin
                    state_d = GNT_D;
                end
            end
            GNT_I:   if (!iwbs.cyc) state_d = IDLE;
            GNT_D:   if (!dwbs.cyc) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request mux towards the slave and response demux back to the owner.
    always_comb begin
        mwbm.addr  = '0;
        mwbm.dat_w = '0;
        mwbm.sel   = '0;
        mwbm.cyc   = 1'b0;
        mwbm.stb   = 1'b0;
        mwbm.we    = 1'b0;
        iwbs.dat_r = '0;
        iwbs.ack   = 1'b0;
        iwbs.err   = 1'b0;
        dwbs.dat_r = '0;
        dwbs.ack   = 1'b0;
        dwbs.err   = 1'b0;
        case (state_q)
            GNT_I: begin
                mwbm.addr  = iwbs.addr;
                mwbm.sel   = SEL_ALL;
                mwbm.cyc   = iwbs.cyc;
                mwbm.stb   = iwbs.stb;
                iwbs.dat_r = mwbm.dat_r;
                iwbs.ack   = mwbm.ack;
                iwbs.err   = mwbm.err | wd_expire;
            end
            GNT_D: begin
                mwbm.addr  = dwbs.addr;
                mwbm.dat_w = dwbs.dat_w;
                mwbm.sel   = dwbs.sel;
                mwbm.cyc   = dwbs.cyc;
                mwbm.stb   = dwbs.stb;
                mwbm.we    = dwbs.we & dwbs.cyc & dwbs.stb;
                dwbs.dat_r = mwbm.dat_r;
                dwbs.ack   = mwbm.ack;
                dwbs.err   = mwbm.err | wd_expire;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Self-checking bench for wb_mem_arbiter: directed scenarios plus randomized traffic vs a behavioural model.
module tb_wb_mem_arbiter;

    localparam int unsigned TIMEOUT_TB = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    // Behavioural model: owner 0=none 1=instruction 2=data; last = previous winner.
    int   m_owner;
    int   m_last;
    int   m_wd;

    wb_mem_arbiter_if ibus ();
    wb_mem_arbiter_if dbus ();
    wb_mem_arbiter_if mbus ();

    wb_mem_arbiter #(
        .TIMEOUT (TIMEOUT_TB)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .iwbs   (ibus),
        .dwbs   (dbus),
        .mwbm   (mbus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not end, got running want finished");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ibus.addr = '0; ibus.dat_w = '0; ibus.sel = '0; ibus.cyc = 0; ibus.stb = 0; ibus.we = 0;
        dbus.addr = '0; dbus.dat_w = '0; dbus.sel = '0; dbus.cyc = 0; dbus.stb = 0; dbus.we = 0;
        mbus.dat_r = '0; mbus.ack = 0; mbus.err = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        ibus.cyc = 1; ibus.stb = 1; ibus.addr = 32'h40;
        dbus.cyc = 1; dbus.stb = 1; dbus.addr = 32'h80;
        mbus.ack = 1;
        rst_n = 0;
        step(); step();
        #1;
        n_cmp++; if (mbus.cyc !== 1'b0) begin n_err++; $display("FAIL reset_cyc: got %0b want 0", mbus.cyc); end
        n_cmp++; if (mbus.addr !== 32'h0) begin n_err++; $display("FAIL reset_addr: got %h want 0", mbus.addr); end
        n_cmp++; if ({ibus.ack, dbus.ack, ibus.err, dbus.err} !== 4'b0) begin n_err++;
            $display("FAIL reset_resp: got %b want 0000", {ibus.ack, dbus.ack, ibus.err, dbus.err}); end
        rst_n = 1; mbus.ack = 0;
        step();
        n_cmp++; if (mbus.addr !== 32'h40 || mbus.cyc !== 1'b1) begin n_err++;
            $display("FAIL reset_first_contest: got addr=%h cyc=%0b want addr=00000040 cyc=1", mbus.addr, mbus.cyc); end
        clear_inputs();
        step(); step();
    endtask

    task automatic test_inst_read();
        clear_inputs();
        step();
        ibus.cyc = 1; ibus.stb = 1; ibus.addr = 32'h100;
        #1;
        n_cmp++; if (mbus.cyc !== 1'b0) begin n_err++; $display("FAIL iread_pre_grant: got cyc=%0b want 0", mbus.cyc); end
        step();
        n_cmp++; if ({mbus.addr, mbus.dat_w, mbus.sel, mbus.we, mbus.cyc, mbus.stb} !== {32'h100, 32'h0, 4'hF, 3'b011}) begin n_err++;
            $display("FAIL iread_grant: got addr=%h dat=%h sel=%h we=%0b want addr=00000100 dat=0 sel=f we=0",
                     mbus.addr, mbus.dat_w, mbus.sel, mbus.we); end
        step();
        mbus.ack = 1; mbus.dat_r = 32'hDEADBEEF;
        #1;
        n_cmp++; if (ibus.ack !== 1'b1 || ibus.dat_r !== 32'hDEADBEEF) begin n_err++;
            $display("FAIL iread_data: got ack=%0b dat=%h want ack=1 dat=deadbeef", ibus.ack, ibus.dat_r); end
        n_cmp++; if (dbus.ack !== 1'b0 || dbus.dat_r !== 32'h0) begin n_err++;
            $display("FAIL iread_other: got ack=%0b dat=%h want ack=0 dat=0", dbus.ack, dbus.dat_r); end
        step();
        clear_inputs();
        step();
        n_cmp++; if (mbus.cyc !== 1'b0) begin n_err++; $display("FAIL iread_release: got cyc=%0b want 0", mbus.cyc); end
    endtask

    task automatic test_alternation();
        clear_inputs();
        rst_n = 0; step(); rst_n = 1;
        ibus.cyc = 1; ibus.stb = 1; ibus.addr = 32'hA0;
        dbus.cyc = 1; dbus.stb = 1; dbus.addr = 32'hB0;
        step();
        n_cmp++; if (mbus.addr !== 32'hA0) begin n_err++; $display("FAIL alt_first: got addr=%h want 000000a0", mbus.addr); end
        ibus.cyc = 0; ibus.stb = 0;
        step();
        n_cmp++; if (mbus.cyc !== 1'b0 || mbus.addr !== 32'h0) begin n_err++;
            $display("FAIL alt_dead_cycle: got cyc=%0b addr=%h want cyc=0 addr=0", mbus.cyc, mbus.addr); end
        step();
        n_cmp++; if (mbus.addr !== 32'hB0 || mbus.cyc !== 1'b1) begin n_err++;
            $display("FAIL alt_second: got addr=%h cyc=%0b want addr=000000b0 cyc=1", mbus.addr, mbus.cyc); end
        ibus.cyc = 1; ibus.stb = 1;
        dbus.cyc = 0; dbus.stb = 0;
        step();
        dbus.cyc = 1; dbus.stb = 1;
        step();
        n_cmp++; if (mbus.addr !== 32'hA0) begin n_err++; $display("FAIL alt_third: got addr=%h want 000000a0", mbus.addr); end
        clear_inputs();
        step(); step();
    endtask

    task automatic test_data_write();
        clear_inputs();
        dbus.cyc = 1; dbus.stb = 1; dbus.we = 1; dbus.addr = 32'h200; dbus.dat_w = 32'h12345678; dbus.sel = 4'b0011;
        step();
        n_cmp++; if ({mbus.we, mbus.sel, mbus.dat_w, mbus.addr} !== {1'b1, 4'b0011, 32'h12345678, 32'h200}) begin n_err++;
            $display("FAIL dwrite_bus: got we=%0b sel=%h dat=%h addr=%h want we=1 sel=3 dat=12345678 addr=00000200",
                     mbus.we, mbus.sel, mbus.dat_w, mbus.addr); end
        dbus.cyc = 0; dbus.stb = 0;
        #1;
        n_cmp++; if (mbus.we !== 1'b0) begin n_err++; $display("FAIL dwrite_gate: got we=%0b want 0", mbus.we); end
        clear_inputs();
        step(); step();
    endtask

    task automatic test_watchdog();
        clear_inputs();
        dbus.cyc = 1; dbus.stb = 1; dbus.addr = 32'h300;
        step();
        for (int k = 0; k <= 10; k++) begin
            logic exp_ack, exp_err;
            mbus.ack = (k >= 9);
            mbus.err = (k == 10);
            exp_ack  = (k >= 9);
            exp_err  = (k == 4) || (k == 10);
            #1;
            n_cmp++; if (dbus.err !== exp_err || dbus.ack !== exp_ack || ibus.err !== 1'b0) begin n_err++;
                $display("FAIL watchdog_k%0d: got err=%0b ack=%0b ierr=%0b want err=%0b ack=%0b ierr=0",
                         k, dbus.err, dbus.ack, ibus.err, exp_err, exp_ack); end
            step();
        end
        clear_inputs();
        step(); step();
    endtask

    task automatic test_reset_mid();
        clear_inputs();
        dbus.cyc = 1; dbus.stb = 1; dbus.addr = 32'h400;
        step();
        mbus.ack = 1;
        rst_n = 0;
        step();
        n_cmp++; if (mbus.cyc !== 1'b0 || {ibus.ack, dbus.ack, ibus.err, dbus.err} !== 4'b0) begin n_err++;
            $display("FAIL reset_mid: got cyc=%0b resp=%b want cyc=0 resp=0000", mbus.cyc, {ibus.ack, dbus.ack, ibus.err, dbus.err}); end
        rst_n = 1; mbus.ack = 0;
        ibus.cyc = 1; ibus.stb = 1; ibus.addr = 32'h500;
        step();
        n_cmp++; if (mbus.addr !== 32'h500) begin n_err++; $display("FAIL reset_mid_contest: got addr=%h want 00000500", mbus.addr); end
        clear_inputs();
        step(); step();
    endtask

    task automatic test_random();
        logic [31:0] e_addr, e_datw, e_idat, e_ddat;
        logic [3:0]  e_sel;
        logic        e_cyc, e_stb, e_we, e_iack, e_ierr, e_dack, e_derr;
        logic        x_cyc, x_stb, forced, ireq, dreq;
        clear_inputs();
        rst_n = 0; step(); rst_n = 1;
        m_owner = 0; m_last = 2; m_wd = 0;
        for (int c = 0; c < 3000; c++) begin
            ibus.cyc   = ibus.cyc ? ($urandom % 8 != 0) : ($urandom % 3 == 0);
            ibus.stb   = ibus.cyc & ($urandom % 4 != 0);
            ibus.addr  = $urandom;
            dbus.cyc   = dbus.cyc ? ($urandom % 8 != 0) : ($urandom % 3 == 0);
            dbus.stb   = dbus.cyc & ($urandom % 4 != 0);
            dbus.we    = $urandom % 2;
            dbus.addr  = $urandom;
            dbus.dat_w = $urandom;
            dbus.sel   = 4'($urandom);
            mbus.dat_r = $urandom;
            mbus.ack   = ($urandom % 5 == 0);
            mbus.err   = ($urandom % 40 == 0);
            rst_n      = ($urandom % 150 != 0);
            #1;
            x_cyc  = (m_owner == 1) ? ibus.cyc : (m_owner == 2) ? dbus.cyc : 1'b0;
            x_stb  = (m_owner == 1) ? ibus.stb : (m_owner == 2) ? dbus.stb : 1'b0;
            forced = (m_owner != 0) && x_stb && !mbus.ack && !mbus.err && (m_wd == int'(TIMEOUT_TB));
            e_addr = (m_owner == 1) ? ibus.addr : (m_owner == 2) ? dbus.addr : 32'h0;
            e_datw = (m_owner == 2) ? dbus.dat_w : 32'h0;
            e_sel  = (m_owner == 1) ? 4'hF : (m_owner == 2) ? dbus.sel : 4'h0;
            e_cyc  = x_cyc;
            e_stb  = x_stb;
            e_we   = (m_owner == 2) && dbus.we && dbus.cyc && dbus.stb;
            e_idat = (m_owner == 1) ? mbus.dat_r : 32'h0;
            e_iack = (m_owner == 1) && mbus.ack;
            e_ierr = (m_owner == 1) && (mbus.err || forced);
            e_ddat = (m_owner == 2) ? mbus.dat_r : 32'h0;
            e_dack = (m_owner == 2) && mbus.ack;
            e_derr = (m_owner == 2) && (mbus.err || forced);
            n_cmp++; if ({mbus.addr, mbus.dat_w, mbus.sel, mbus.cyc, mbus.stb, mbus.we} !== {e_addr, e_datw, e_sel, e_cyc, e_stb, e_we}) begin
                n_err++; $display("FAIL rand_slave_bus c=%0d: got %h want %h", c,
                    {mbus.addr, mbus.dat_w, mbus.sel, mbus.cyc, mbus.stb, mbus.we}, {e_addr, e_datw, e_sel, e_cyc, e_stb, e_we}); end
            n_cmp++; if ({ibus.dat_r, ibus.ack, ibus.err} !== {e_idat, e_iack, e_ierr}) begin
                n_err++; $display("FAIL rand_inst_resp c=%0d: got %h want %h", c, {ibus.dat_r, ibus.ack, ibus.err}, {e_idat, e_iack, e_ierr}); end
            n_cmp++; if ({dbus.dat_r, dbus.ack, dbus.err} !== {e_ddat, e_dack, e_derr}) begin
                n_err++; $display("FAIL rand_data_resp c=%0d: got %h want %h", c, {dbus.dat_r, dbus.ack, dbus.err}, {e_ddat, e_dack, e_derr}); end
            ireq = ibus.cyc && ibus.stb;
            dreq = dbus.cyc && dbus.stb;
            @(posedge clk);
            if (!rst_n) begin
                m_owner = 0; m_last = 2; m_wd = 0;
            end else begin
                if (m_owner == 0 || mbus.ack || mbus.err || forced) m_wd = 0;
                else if (x_stb) m_wd = m_wd + 1;
                if (m_owner == 0) begin
                    if (ireq && dreq) m_owner = (m_last == 1) ? 2 : 1;
                    else if (ireq)    m_owner = 1;
                    else if (dreq)    m_owner = 2;
                    if (m_owner != 0) m_last = m_owner;
                end else if (!x_cyc) begin
                    m_owner = 0;
                end
            end
            #1;
        end
        rst_n = 1;
        clear_inputs();
        step();
    endtask

    initial begin
        rst_n = 0;
        clear_inputs();
        test_reset();
        test_inst_read();
        test_alternation();
        test_data_write();
        test_watchdog();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
